// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the word-framed bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Width of the bit-position counter for a word of w bits (w >= 2).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_addsub_word_fa.sv
// Combinational one-bit full adder used as the serial arithmetic core.
module serial_fa_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  // Sum and majority carry.
  always_comb begin
    s_o = a_i ^ b_i ^ c_i;
    c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  end

endmodule

// File: rtl/serial_addsub_word.sv
// Word-framed bit-serial adder/subtractor, LSB first, with stall and abort.
// Optional macro SERIAL_ADDSUB_OVF_EN builds the signed-overflow flag;
// without it the overflow port is tied low.
module serial_addsub_word
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             sof,
  input  logic             sub,
  input  logic             a,
  input  logic             b,
  output logic             sum,
  output logic             sum_valid,
  output logic             busy,
  output logic             done,
  output logic             cout,
  output logic             overflow,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               carry_q, carry_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               sum_q, sum_d;
  logic               sum_valid_q, sum_valid_d;
  logic               done_q, done_d;
  logic               cout_q, cout_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               start;
  logic               accept;
  logic               last;
  logic               mode_eff;
  logic               cin;
  logic [CW-1:0]      bit_idx;
  logic               b_eff;
  logic               fa_s;
  logic               fa_c;

  // Beat qualification: an sof beat always (re)starts a word at bit 0.
  always_comb begin
    start    = in_valid & sof;
    accept   = in_valid & (sof | (state_q == RUN));
    mode_eff = start ? sub : mode_q;
    cin      = start ? sub : carry_q;
    bit_idx  = start ? '0 : count_q;
    b_eff    = b ^ mode_eff;
    last     = accept & (bit_idx == LAST_IDX);
  end

  serial_fa_bit u_fa (
    .a_i (a),
    .b_i (b_eff),
    .c_i (cin),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: enter RUN on any accepted beat, leave after the MSB.
  always_comb begin
    state_d = state_q;
    if (accept) state_d = last ? IDLE : RUN;
  end

  // Datapath and registered-output next values.
  always_comb begin
    count_d     = count_q;
    carry_d     = carry_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    done_d      = 1'b0;
    cout_d      = cout_q;
    result_d    = result_q;
    if (accept) begin
      mode_d         = mode_eff;
      carry_d        = fa_c;
      acc_d[bit_idx] = fa_s;
      sum_d          = fa_s;
      sum_valid_d    = 1'b1;
      count_d        = last ? '0 : CW'(bit_idx + CW'(1));
    end
    if (last) begin
      done_d   = 1'b1;
      cout_d   = fa_c;
      result_d = acc_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      carry_q     <= 1'b0;
      mode_q      <= 1'b0;
      acc_q       <= '0;
      sum_q       <= 1'b0;
      sum_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cout_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      count_q     <= count_d;
      carry_q     <= carry_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      done_q      <= done_d;
      cout_q      <= cout_d;
      result_q    <= result_d;
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (last) ovf_d = cin ^ fa_c;
  end

  // Overflow flag register, held between words.
  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign cout      = cout_q;
  assign result    = result_q;

endmodule

// File: tb/tb_serial_addsub_word.sv
// Scoreboard bench for serial_addsub_word at WIDTH=4 with directed vectors.
module tb_serial_addsub_word;

  localparam int unsigned W = 4;
`ifdef SERIAL_ADDSUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ovf;
  } word_exp_t;

  logic         clk = 1'b0;
  logic         reset, in_valid, sof, sub, a, b;
  logic         sum, sum_valid, busy, done, cout, overflow;
  logic [W-1:0] result;

  logic      q_bits[$];
  word_exp_t q_words[$];
  int        done_cyc[$];
  int        checks = 0;
  int        failures = 0;
  int        cyc = 0;
  int        words_pushed = 0;
  int        done_seen = 0;

  serial_addsub_word #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .sof       (sof),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .sum_valid (sum_valid),
    .busy      (busy),
    .done      (done),
    .cout      (cout),
    .overflow  (overflow),
    .result    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One input beat; optionally pushes the expected serial sum bit.
  task automatic beat(input logic v, input logic s, input logic sb,
                      input logic aa, input logic bb,
                      input logic exp_s, input bit push);
    in_valid = v; sof = s; sub = sb; a = aa; b = bb;
    if (push) q_bits.push_back(exp_s);
    @(posedge clk); #1;
    in_valid = 1'b0; sof = 1'b0; sub = 1'b0; a = 1'b0; b = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Full word; the serial sum stream equals the result bits LSB first.
  task automatic word(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sb,
                      input logic [W-1:0] er, input logic eco, input logic eovf);
    word_exp_t e;
    for (int i = 0; i < int'(W); i++) begin
      if (i == int'(W) - 1) begin
        e.res = er; e.co = eco; e.ovf = eovf & OVF_EN;
        q_words.push_back(e);
        words_pushed++;
      end
      beat(1'b1, i == 0, sb, av[i], bv[i], er[i], 1'b1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sum"}, int'(sum), 0);
    check({tag, "_sum_valid"}, int'(sum_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_cout"}, int'(cout), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
    check({tag, "_result"}, int'(result), 0);
  endtask

  // Monitor: compare every presented sum bit and every completed word.
  always @(negedge clk) begin
    if (sum_valid === 1'b1) begin
      if (q_bits.size() == 0) check("sum_unexpected", 1, 0);
      else check("sum_bit", int'(sum), int'(q_bits.pop_front()));
    end
    if (done === 1'b1) begin
      word_exp_t e;
      done_seen++;
      done_cyc.push_back(cyc);
      if (q_words.size() == 0) check("done_unexpected", 1, 0);
      else begin
        e = q_words.pop_front();
        check("result", int'(result), int'(e.res));
        check("cout", int'(cout), int'(e.co));
        check("overflow", int'(overflow), int'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; in_valid = 1'b0; sof = 1'b0; sub = 1'b0; a = 1'b0; b = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Ignored beats in IDLE: valid without sof, sof without valid.
    beat(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("idle_busy", int'(busy), 0);

    // 5+3 then 7+9 back to back.
    done_cyc.delete();
    word(4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1);
    word(4'b0111, 4'b1001, 1'b0, 4'b0000, 1'b1, 1'b0);
    idle(2);
    if (done_cyc.size() == 2) check("b2b_done_gap", done_cyc[1] - done_cyc[0], 4);
    else check("b2b_done_count", done_cyc.size(), 2);

    // 3-5 then 7-7.
    word(4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0, 1'b0);
    word(4'b0111, 4'b0111, 1'b1, 4'b0000, 1'b1, 1'b0);
    idle(3);
    check("held_result", int'(result), 0);
    check("held_cout", int'(cout), 1);
    check("held_busy", int'(busy), 0);

    // 5+3 with two stall cycles after bit 1 (one carrying an unqualified sof).
    done_cyc.delete();
    beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    k = cyc;
    check("run_busy", int'(busy), 1);
    beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    beat(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("stall_busy", int'(busy), 1);
    q_words.push_back('{res: 4'b1000, co: 1'b0, ovf: OVF_EN});
    words_pushed++;
    beat(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    if (done_cyc.size() == 1) check("stall_done_latency", done_cyc[0] - k, 5);
    else check("stall_done_count", done_cyc.size(), 1);

    // Abort: 5+3 restarted by sof at bit 2, becoming 2+1.
    beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    word(4'b0010, 4'b0001, 1'b0, 4'b0011, 1'b0, 1'b0);
    idle(2);

    // Reset mid-word, then 1+1.
    beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    beat(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    check_all_zero("midreset");
    word(4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0);
    idle(3);

    check("leftover_bits", q_bits.size(), 0);
    check("leftover_words", q_words.size(), 0);
    check("done_total", done_seen, words_pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
